// File: rtl/variance_cache_ctrl_pkg.sv
// Shared widths, corner count and FSM state encoding for the variance-cache
// corner fetch controller.
package pkg_varianceCache;

  localparam int ADDR_WIDTH   = 2;
  localparam int WORD_SIZE    = 16;
  localparam int WORD_SIZE_SQ = 32;
  localparam int ELM_WIDTH    = 8;
  localparam int NUM_CORNERS  = 2 ** ADDR_WIDTH;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/variance_cache_ctrl_corner_gen.sv
// Combinational corner address generator: bit 0 of the counter selects the
// right column, bit 1 the bottom row; additions wrap at the coordinate width.
module variance_corner_gen
  import pkg_varianceCache::*;
#(
  parameter int CNT_WIDTH = ADDR_WIDTH,
  parameter int EW        = ELM_WIDTH
) (
  input  logic [CNT_WIDTH-1:0] counter,
  input  logic [EW-1:0]        x,
  input  logic [EW-1:0]        y,
  input  logic [EW-1:0]        s,
  output logic [EW-1:0]        rd_x,
  output logic [EW-1:0]        rd_y
);

  always_comb begin
    rd_x = counter[0] ? x + s : x;
    rd_y = counter[1] ? y + s : y;
  end

endmodule

// File: rtl/variance_cache_ctrl.sv
// Fetches the four integral/squared-integral corner words of one window and
// writes them into the variance cache slots 0..3, then pulses done.
module variance_cache_ctrl
  import pkg_varianceCache::*;
#(
  parameter int ADDR_WIDTH   = pkg_varianceCache::ADDR_WIDTH,
  parameter int WORD_SIZE    = pkg_varianceCache::WORD_SIZE,
  parameter int WORD_SIZE_SQ = pkg_varianceCache::WORD_SIZE_SQ,
  parameter int ELM_WIDTH    = pkg_varianceCache::ELM_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [ELM_WIDTH-1:0]    winX_i,
  input  logic [ELM_WIDTH-1:0]    winY_i,
  input  logic [ELM_WIDTH-1:0]    winSize_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    rd_req_o,
  output logic [ELM_WIDTH-1:0]    rd_x_o,
  output logic [ELM_WIDTH-1:0]    rd_y_o,
  input  logic                    rd_ack_i,
  input  logic [WORD_SIZE-1:0]    ii_data_i,
  input  logic [WORD_SIZE_SQ-1:0] sq_data_i,
  output logic                    vc_we_o,
  output logic [ADDR_WIDTH-1:0]   vc_addr_o,
  output logic [WORD_SIZE-1:0]    vc_ii_o,
  output logic [WORD_SIZE_SQ-1:0] vc_sq_o
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ELM_WIDTH-1:0]    win_x_q, win_x_d;
  logic [ELM_WIDTH-1:0]    win_y_q, win_y_d;
  logic [ELM_WIDTH-1:0]    win_s_q, win_s_d;
  logic [WORD_SIZE-1:0]    ii_q, ii_d;
  logic [WORD_SIZE_SQ-1:0] sq_q, sq_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rd_req_q, rd_req_d;
  logic [ELM_WIDTH-1:0]    rd_x_q, rd_x_d;
  logic [ELM_WIDTH-1:0]    rd_y_q, rd_y_d;
  logic                    vc_we_q, vc_we_d;
  logic [ADDR_WIDTH-1:0]   vc_addr_q, vc_addr_d;
  logic [ELM_WIDTH-1:0]    gen_x, gen_y;

  // Addresses are generated from next-state values so they can be registered
  // alongside rd_req and appear in the same cycle as the request.
  variance_corner_gen #(
    .CNT_WIDTH (ADDR_WIDTH),
    .EW        (ELM_WIDTH)
  ) u_corner_gen (
    .counter (cnt_d),
    .x       (win_x_d),
    .y       (win_y_d),
    .s       (win_s_d),
    .rd_x    (gen_x),
    .rd_y    (gen_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    win_s_d = win_s_q;
    ii_d    = ii_q;
    sq_d    = sq_q;

    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            win_x_d = winX_i;
            win_y_d = winY_i;
            win_s_d = winSize_i;
            cnt_d   = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (rd_ack_i) begin
            ii_d    = ii_data_i;
            sq_d    = sq_data_i;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (cnt_q == '1) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d    = (state_d != ST_IDLE);
    rd_req_d  = (state_d == ST_FETCH);
    vc_we_d   = (state_d == ST_WRITE);
    done_d    = (state_d == ST_DONE);
    rd_x_d    = rd_req_d ? gen_x : '0;
    rd_y_d    = rd_req_d ? gen_y : '0;
    vc_addr_d = vc_we_d ? cnt_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      win_x_q   <= '0;
      win_y_q   <= '0;
      win_s_q   <= '0;
      ii_q      <= '0;
      sq_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      vc_we_q   <= 1'b0;
      vc_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_x_q   <= win_x_d;
      win_y_q   <= win_y_d;
      win_s_q   <= win_s_d;
      ii_q      <= ii_d;
      sq_q      <= sq_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_req_q  <= rd_req_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      vc_we_q   <= vc_we_d;
      vc_addr_q <= vc_addr_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_req_o  = rd_req_q;
  assign rd_x_o    = rd_x_q;
  assign rd_y_o    = rd_y_q;
  assign vc_we_o   = vc_we_q;
  assign vc_addr_o = vc_addr_q;
  assign vc_ii_o   = ii_q;
  assign vc_sq_o   = sq_q;

endmodule

// File: tb/tb_variance_cache_ctrl.sv
// Scoreboard bench: the driver issues windows with chosen ack delays and pushes
// expected reads/writes/done/idle events; a negedge monitor pops and compares.
module tb_variance_cache_ctrl;
  import pkg_varianceCache::*;

  localparam int EW = ELM_WIDTH;
  localparam int WS = WORD_SIZE;
  localparam int WQ = WORD_SIZE_SQ;
  localparam int AW = ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, abort_i, rd_ack_i;
  logic [EW-1:0] winX_i, winY_i, winSize_i;
  logic          busy_o, done_o, rd_req_o, vc_we_o;
  logic [EW-1:0] rd_x_o, rd_y_o;
  logic [WS-1:0] ii_data_i, vc_ii_o;
  logic [WQ-1:0] sq_data_i, vc_sq_o;
  logic [AW-1:0] vc_addr_o;

  variance_cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .winX_i    (winX_i),
    .winY_i    (winY_i),
    .winSize_i (winSize_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rd_req_o  (rd_req_o),
    .rd_x_o    (rd_x_o),
    .rd_y_o    (rd_y_o),
    .rd_ack_i  (rd_ack_i),
    .ii_data_i (ii_data_i),
    .sq_data_i (sq_data_i),
    .vc_we_o   (vc_we_o),
    .vc_addr_o (vc_addr_o),
    .vc_ii_o   (vc_ii_o),
    .vc_sq_o   (vc_sq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [AW-1:0] addr;
    logic [WS-1:0] ii;
    logic [WQ-1:0] sq;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [EW-1:0] x;
    logic [EW-1:0] y;
  } rd_t;

  wr_t wr_q[$];
  rd_t rd_q[$];
  int  done_q[$];
  int  idle_q[$];

  int checks = 0;
  int errors = 0;
  int dly[4];
  logic [WS-1:0] salt_ii;
  logic [WQ-1:0] salt_sq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WS-1:0] f_ii(input logic [EW-1:0] x, input logic [EW-1:0] y);
    return WS'({x, y}) ^ salt_ii;
  endfunction

  function automatic logic [WQ-1:0] f_sq(input logic [EW-1:0] x, input logic [EW-1:0] y);
    return WQ'({y, x, x ^ y, 8'h5a}) ^ salt_sq;
  endfunction

  // Corner k of window (x,y,s): odd k adds s to the column, k>=2 adds s to the row.
  function automatic void corner(input int k, input logic [EW-1:0] x, input logic [EW-1:0] y,
                                 input logic [EW-1:0] s, output logic [EW-1:0] ex,
                                 output logic [EW-1:0] ey);
    int m;
    m  = 1 << EW;
    ex = EW'((int'(x) + (((k % 2) == 1) ? int'(s) : 0)) % m);
    ey = EW'((int'(y) + ((k >= 2) ? int'(s) : 0)) % m);
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (vc_we_o) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 64'(vc_addr_o), 64'hFFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", 64'(vc_addr_o), 64'(e.addr));
          check("wr_ii", 64'(vc_ii_o), 64'(e.ii));
          check("wr_sq", 64'(vc_sq_o), 64'(e.sq));
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          $display("write slot %0d ii %h sq %h cycle %0d", vc_addr_o, vc_ii_o, vc_sq_o, cyc);
        end
      end
      if (rd_req_o) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", {48'd0, rd_x_o, rd_y_o}, 64'hFFFF_FFFF);
        end else begin
          check("rd_x", 64'(rd_x_o), 64'(rd_q[0].x));
          check("rd_y", 64'(rd_y_o), 64'(rd_q[0].y));
          if (rd_ack_i || abort_i) void'(rd_q.pop_front());
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 64'(cyc), 64'hFFFF);
        end else begin
          int ed;
          ed = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(ed));
          $display("done cycle %0d", cyc);
        end
      end
      if (idle_q.size() != 0 && idle_q[0] == cyc) begin
        void'(idle_q.pop_front());
        check("idle_outputs", {60'd0, busy_o, rd_req_o, vc_we_o, done_o}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_rdreq"}, 64'(rd_req_o), 64'd0);
    check({tag, "_we"}, 64'(vc_we_o), 64'd0);
    check({tag, "_addr"}, 64'(vc_addr_o), 64'd0);
    check({tag, "_rdxy"}, {48'd0, rd_x_o, rd_y_o}, 64'd0);
    check({tag, "_ii"}, 64'(vc_ii_o), 64'd0);
    check({tag, "_sq"}, 64'(vc_sq_o), 64'd0);
  endtask

  // Caller is 1 time unit after a rising edge with the DUT idle.
  // abort_k/rst_k select a corner to abort in (FETCH) or reset in (WRITE); -1 = none.
  task automatic run_window(input logic [EW-1:0] x, input logic [EW-1:0] y,
                            input logic [EW-1:0] s, input int abort_k, input bit abort_ack,
                            input int rst_k, input bit poke);
    int t0;
    int acc;
    logic [EW-1:0] ex, ey;
    winX_i    = x;
    winY_i    = y;
    winSize_i = s;
    start_i   = 1'b1;
    t0        = cyc;
    tick();
    start_i   = 1'b0;
    winX_i    = EW'($urandom);
    winY_i    = EW'($urandom);
    winSize_i = EW'($urandom);
    acc       = 0;
    for (int k = 0; k < 4; k++) begin
      corner(k, x, y, s, ex, ey);
      rd_q.push_back('{x: ex, y: ey});
      rd_ack_i = 1'b0;
      for (int j = 0; j < dly[k]; j++) begin
        start_i = poke;
        winX_i  = EW'($urandom);
        winY_i  = EW'($urandom);
        tick();
      end
      start_i = 1'b0;
      if (k == abort_k) begin
        abort_i   = 1'b1;
        rd_ack_i  = abort_ack;
        start_i   = abort_ack;
        ii_data_i = WS'($urandom);
        sq_data_i = WQ'($urandom);
        idle_q.push_back(cyc + 1);
        tick();
        abort_i  = 1'b0;
        rd_ack_i = 1'b0;
        start_i  = 1'b0;
        return;
      end
      rd_ack_i  = 1'b1;
      ii_data_i = f_ii(ex, ey);
      sq_data_i = f_sq(ex, ey);
      acc += dly[k];
      if (k != rst_k)
        wr_q.push_back('{addr: AW'(k), ii: f_ii(ex, ey), sq: f_sq(ex, ey), cyc: t0 + 2 * (k + 1) + acc});
      tick();
      // WRITE cycle: ack, data and start here must all be ignored.
      rd_ack_i  = 1'($urandom);
      ii_data_i = WS'($urandom);
      sq_data_i = WQ'($urandom);
      start_i   = poke;
      winX_i    = EW'($urandom);
      if (k == rst_k) begin
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        rd_ack_i = 1'b0;
        start_i  = 1'b0;
        tick();
        rst = 1'b0;
        idle_q.push_back(cyc);
        tick();
        return;
      end
      tick();
      start_i = 1'b0;
    end
    done_q.push_back(t0 + 9 + acc);
    rd_ack_i  = 1'($urandom);
    ii_data_i = WS'($urandom);
    tick();
    rd_ack_i = 1'b0;
    idle_q.push_back(cyc);
  endtask

  task automatic set_dly(input int a, input int b, input int c, input int d);
    dly[0] = a;
    dly[1] = b;
    dly[2] = c;
    dly[3] = d;
  endtask

  initial begin
    salt_ii   = WS'($urandom);
    salt_sq   = $urandom;
    rst       = 1'b1;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    rd_ack_i  = 1'b0;
    winX_i    = '0;
    winY_i    = '0;
    winSize_i = '0;
    ii_data_i = '0;
    sq_data_i = '0;
    #3 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    set_dly(0, 0, 0, 0);
    run_window(8'd10, 8'd20, 8'd24, -1, 1'b0, -1, 1'b0);
    set_dly(3, 3, 3, 3);
    run_window(8'd7, 8'd99, 8'd40, -1, 1'b0, -1, 1'b0);
    set_dly(0, 0, 0, 0);
    run_window(8'd250, 8'd5, 8'd10, -1, 1'b0, -1, 1'b0);
    set_dly(0, 1, 2, 0);
    run_window(8'd33, 8'd44, 8'd5, 2, 1'b1, -1, 1'b0);
    set_dly(0, 0, 0, 0);
    run_window(8'd1, 8'd2, 8'd3, -1, 1'b0, -1, 1'b0);
    set_dly(1, 2, 1, 0);
    run_window(8'd60, 8'd70, 8'd16, -1, 1'b0, -1, 1'b1);
    set_dly(0, 2, 0, 0);
    run_window(8'd90, 8'd91, 8'd12, -1, 1'b0, 1, 1'b0);
    set_dly(0, 0, 0, 0);
    run_window(8'd200, 8'd240, 8'd30, -1, 1'b0, -1, 1'b0);

    // Abort wins over start while idle.
    start_i = 1'b1;
    abort_i = 1'b1;
    winX_i  = 8'd77;
    idle_q.push_back(cyc + 1);
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    tick();

    for (int n = 0; n < 24; n++) begin
      int ak;
      set_dly(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_window(EW'($urandom), EW'($urandom), EW'($urandom), ak, 1'($urandom), -1,
                 1'($urandom));
    end

    repeat (4) tick();
    check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    check("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    check("done_queue_empty", 64'(done_q.size()), 64'd0);
    check("idle_queue_empty", 64'(idle_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/variance_cache_ctrl.md
VARIANCE_CACHE_CTRL -- requirements
Module: variance_cache_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDR_WIDTH, pkg_varianceCache::ADDR_WIDTH (2), variance-cache slot address width (4 corner slots).
- WORD_SIZE, pkg_varianceCache::WORD_SIZE, integral-image word width.
- WORD_SIZE_SQ, pkg_varianceCache::WORD_SIZE_SQ, squared-integral-image word width.
- ELM_WIDTH, pkg_varianceCache::ELM_WIDTH, coordinate and window-size width.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- start_i, in, 1, begin corner fetch for one window.
- abort_i, in, 1, cancel the current fetch.
- winX_i, in, ELM_WIDTH, window left column.
- winY_i, in, ELM_WIDTH, window top row.
- winSize_i, in, ELM_WIDTH, window side length s.
- busy_o, out, 1, high in every non-IDLE state.
- done_o, out, 1, one-cycle pulse when all 4 slots are written.
- rd_req_o, out, 1, read request to the integral and SQ image caches.
- rd_x_o, out, ELM_WIDTH, read column.
- rd_y_o, out, ELM_WIDTH, read row.
- rd_ack_i, in, 1, both cache data words are valid this cycle.
- ii_data_i, in, WORD_SIZE, integral-image word.
- sq_data_i, in, WORD_SIZE_SQ, squared-integral word.
- vc_we_o, out, 1, variance-cache write enable.
- vc_addr_o, out, ADDR_WIDTH, variance-cache slot.
- vc_ii_o, out, WORD_SIZE, captured integral word.
- vc_sq_o, out, WORD_SIZE_SQ, captured squared word.
REQ-003 The block SHALL use one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, WRITE and DONE.
REQ-005 In IDLE, start_i=1 SHALL register winX_i, winY_i and winSize_i, clear the corner counter and enter FETCH on the next cycle.
REQ-006 In FETCH, rd_req_o SHALL be 1 and the read address SHALL be held stable until rd_ack_i=1.
REQ-007 In the rd_ack_i=1 cycle, ii_data_i and sq_data_i SHALL be captured and the FSM SHALL enter WRITE.
REQ-008 WRITE SHALL last exactly one cycle with vc_we_o=1, vc_addr_o equal to the corner counter, and vc_ii_o/vc_sq_o equal to the captured words.
REQ-009 After WRITE, the counter SHALL increment and the FSM SHALL return to FETCH; after the counter-3 write it SHALL go to DONE instead.
REQ-010 DONE SHALL last one cycle with done_o=1, then the FSM SHALL return to IDLE.
REQ-011 Corner addresses SHALL be, for counter values 0 to 3:
- 0: (x, y).
- 1: (x+s, y).
- 2: (x, y+s).
- 3: (x+s, y+s).
REQ-012 Corner additions SHALL be ELM_WIDTH-bit and wrap modulo 2^ELM_WIDTH with no saturation and no error flag.
REQ-013 Minimum latency with rd_ack_i tied high: start_i sampled in cycle 0 SHALL give done_o=1 in cycle 9, with vc_we_o=1 in cycles 2, 4, 6 and 8.
REQ-014 start_i SHALL be ignored when busy_o=1; new window inputs SHALL NOT disturb the registered values.
REQ-015 rd_ack_i SHALL be ignored outside FETCH.
REQ-016 abort_i=1 in any state SHALL return the FSM to IDLE on the next edge, with no further vc_we_o and no done_o.
REQ-017 abort_i SHALL take priority over rd_ack_i and start_i in the same cycle.
REQ-018 Outputs rd_req_o, vc_we_o and done_o SHALL be registered and glitch-free.

Reset
REQ-019 While rst=1, the FSM SHALL be IDLE and every output SHALL be 0 (busy_o, done_o, rd_req_o, vc_we_o, vc_addr_o, rd_x_o, rd_y_o, vc_ii_o, vc_sq_o).
REQ-020 rst asserted mid-fetch SHALL discard the partial window; after release, a fresh start_i is required.

Structure
REQ-021 pkg_varianceCache SHALL gain the FSM state typedef and the constant NUM_CORNERS = 2**ADDR_WIDTH.
REQ-022 Corner offset selection SHALL be a combinational sub-module, variance_corner_gen, with inputs counter, x, y, s and outputs rd_x, rd_y.

Verification
REQ-023 Run x=10, y=20, s=24, ack tied high: reads SHALL be (10,20), (34,20), (10,44), (34,44) to slots 0 to 3, with done_o in cycle 9.
REQ-024 Run ack delayed by 3 cycles per corner: rd_req_o and the address SHALL hold stable for 4 cycles each, the data SHALL match, and done_o SHALL occur in cycle 21.
REQ-025 Run ELM_WIDTH=8, x=250, s=10: corner 1 column SHALL be 4 (wrap).
REQ-026 Assert abort_i during corner 2 FETCH: no slot-2 or slot-3 write and no done_o SHALL occur; the next start_i SHALL run a full clean sequence.
REQ-027 Pulse start_i during busy with different coordinates: the sequence SHALL be unaffected.
REQ-028 Assert rst during corner 1 WRITE: all outputs SHALL be 0 immediately (asynchronously), and the FSM SHALL be IDLE after release.
